gate_op_sched: RTL and testbench

Round-robin scheduler that shares one W-bit logic-gate unit (AND/NAND/OR/NOR/NOT/XOR/XNOR) between two requesters. Each requester presents an opcode and two operands with a valid/ready handshake. The block arbitrates between them, sequences the shared unit through a three-state FSM, and returns the result on a single response channel tagged with the requester id. It sits between client logic and the gate datapath, so the datapath is never driven by two masters at once.

---
 rtl/gate_sched_pkg.sv | 21 ++
 rtl/gate_op_sched_alu.sv | 32 +++
 rtl/gate_op_sched.sv | 125 ++++++++++++
 tb/tb_gate_op_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sched_pkg.sv
// Shared opcode and FSM-state definitions for the gate_op_sched scheduler.
package gate_sched_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND     = 3'd0;
    localparam logic [OP_W-1:0] OP_NAND    = 3'd1;
    localparam logic [OP_W-1:0] OP_OR      = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR     = 3'd3;
    localparam logic [OP_W-1:0] OP_NOT     = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR     = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR    = 3'd6;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/gate_op_sched_alu.sv
// gate_alu: purely combinational W-bit bitwise gate unit; opcode 7 flags err.
module gate_alu
    import gate_sched_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [W-1:0]    y,
    output logic            err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_NAND: y = ~(a & b);
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_NOT:  y = ~a;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: begin
                y   = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/gate_op_sched.sv
// Round-robin scheduler sharing one gate_alu between two requesters.
// Optional grant counters are built when GATE_SCHED_STATS_EN is defined.
module gate_op_sched
    import gate_sched_pkg::*;
#(
    parameter int W = 8
`ifdef GATE_SCHED_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OP_W-1:0] req0_op,
    input  logic [W-1:0]    req0_a,
    input  logic [W-1:0]    req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OP_W-1:0] req1_op,
    input  logic [W-1:0]    req1_a,
    input  logic [W-1:0]    req1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_data,
    output logic            rsp_err,
`ifdef GATE_SCHED_STATS_EN
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1,
`endif
    output logic            busy
);

    state_t          state_q, state_d;
    logic            prio_q;   // 0 favours req0 on contention
    logic            gnt_id;
    logic            accept;
    logic [OP_W-1:0] op_p0;
    logic [W-1:0]    a_p0, b_p0;
    logic            id_p0;
    logic [W-1:0]    alu_y;
    logic            alu_err;

    always_comb begin
        state_d    = state_q;
        gnt_id     = 1'b0;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_id     = (req0_valid && req1_valid) ? prio_q : req1_valid;
                accept     = req0_valid || req1_valid;
                req0_ready = req0_valid && !gnt_id;
                req1_ready = req1_valid && gnt_id;
                if (accept) state_d = ST_EXEC;
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage p0: operands captured at the handshake edge only
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= gnt_id ? req1_op : req0_op;
            a_p0  <= gnt_id ? req1_a  : req0_a;
            b_p0  <= gnt_id ? req1_b  : req0_b;
            id_p0 <= gnt_id;
        end
    end

    gate_alu #(.W(W)) u_alu (
        .op  (op_p0),
        .a   (a_p0),
        .b   (b_p0),
        .y   (alu_y),
        .err (alu_err)
    );

    // Response stage: result registered in EXEC, held until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prio_q    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_EXEC) begin
                rsp_valid <= 1'b1;
                rsp_data  <= alu_y;
                rsp_err   <= alu_err;
                rsp_id    <= id_p0;
            end else if (state_q == ST_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                prio_q    <= ~rsp_id;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

`ifdef GATE_SCHED_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (accept) begin
            if (gnt_id) gnt_cnt1 <= sat_inc(gnt_cnt1);
            else        gnt_cnt0 <= sat_inc(gnt_cnt0);
        end
    end
`endif

endmodule

// File: tb/tb_gate_op_sched.sv
// Bench for gate_op_sched: directed steps plus random traffic against a transaction-level model.
module tb_gate_op_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [7:0] rsp_data;
`ifdef GATE_SCHED_STATS_EN
    logic [1:0] gnt_cnt0, gnt_cnt1;
`endif

    int tests = 0;
    int fails = 0;

    // Model state: op in flight, response visible, expected response, priority
    bit         m_busy = 0;
    bit         m_vis  = 0;
    bit         m_prio = 0;
    bit         m_id   = 0;
    logic [7:0] m_data = '0;
    bit         m_err  = 0;
    int         m_c0   = 0;
    int         m_c1   = 0;
    bit         obs_ids[$];

    gate_op_sched #(
        .W(8)
`ifdef GATE_SCHED_STATS_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
`ifdef GATE_SCHED_STATS_EN
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference gate function: returns {err, y}
    function automatic logic [8:0] gate_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a & b};
            3'd1:    return {1'b0, ~(a & b)};
            3'd2:    return {1'b0, a | b};
            3'd3:    return {1'b0, ~(a | b)};
            3'd4:    return {1'b0, ~a};
            3'd5:    return {1'b0, a ^ b};
            3'd6:    return {1'b0, ~(a ^ b)};
            default: return {1'b1, 8'h00};
        endcase
    endfunction

    function automatic int sat2(input int c);
        return (c >= 3) ? 3 : c + 1;
    endfunction

    // One clock cycle: drive at negedge, check, then advance the model across the next edge
    task automatic step(input bit v0, input logic [2:0] o0, input logic [7:0] a0, input logic [7:0] b0,
                        input bit v1, input logic [2:0] o1, input logic [7:0] a1, input logic [7:0] b1,
                        input bit rr);
        bit win;
        logic [8:0] r;
        @(negedge clk);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
        #1;
        win = (v0 && v1) ? m_prio : v1;
        chk("req0_ready", req0_ready, !m_busy && v0 && !win);
        chk("req1_ready", req1_ready, !m_busy && v1 && win);
        chk("busy", busy, m_busy);
        chk("rsp_valid", rsp_valid, m_vis);
        if (m_vis) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_err", rsp_err, m_err);
        end
`ifdef GATE_SCHED_STATS_EN
        chk("gnt_cnt0", gnt_cnt0, m_c0);
        chk("gnt_cnt1", gnt_cnt1, m_c1);
`endif
        if (rsp_valid && rr) obs_ids.push_back(rsp_id);
        if (!m_busy) begin
            if (v0 || v1) begin
                r      = win ? gate_ref(o1, a1, b1) : gate_ref(o0, a0, b0);
                m_busy = 1;
                m_vis  = 0;
                m_id   = win;
                m_data = r[7:0];
                m_err  = r[8];
                if (win) m_c1 = sat2(m_c1);
                else     m_c0 = sat2(m_c0);
            end
        end else if (!m_vis) begin
            m_vis = 1;
        end else if (rr) begin
            m_vis  = 0;
            m_busy = 0;
            m_prio = !m_id;
        end
    endtask

    task automatic idle(input bit rr);
        step(0, 3'd0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, rr);
    endtask

    task automatic run_op(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input bit ee);
        if (id) step(0, 3'd0, 8'h00, 8'h00, 1, op, a, b, 1);
        else    step(1, op, a, b, 0, 3'd0, 8'h00, 8'h00, 1);
        idle(1);
        idle(1);
        chk("op_valid", rsp_valid, 1'b1);
        chk("op_data", rsp_data, ed);
        chk("op_err", rsp_err, ee);
        chk("op_id", rsp_id, id);
    endtask

    task automatic rnd_step(input bit v0, input bit v1, input bit rr);
        step(v0, 3'($urandom), 8'($urandom), 8'($urandom),
             v1, 3'($urandom), 8'($urandom), 8'($urandom), rr);
    endtask

    initial begin
        logic [7:0] held;
        rst = 1'b1;
        req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp_ready  = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single op and every opcode; last one from req1 leaves priority on req0
        run_op(0, 3'd0, 8'hF0, 8'h3C, 8'h30, 0);
        run_op(0, 3'd1, 8'hF0, 8'h3C, 8'hCF, 0);
        run_op(1, 3'd2, 8'hF0, 8'h3C, 8'hFC, 0);
        run_op(0, 3'd3, 8'hF0, 8'h3C, 8'h03, 0);
        run_op(1, 3'd4, 8'hF0, 8'h3C, 8'h0F, 0);
        run_op(0, 3'd5, 8'hF0, 8'h3C, 8'hCC, 0);
        run_op(0, 3'd6, 8'hF0, 8'h3C, 8'h33, 0);
        run_op(1, 3'd7, 8'hF0, 8'h3C, 8'h00, 1);

        // Contention: both valid for four ops
        obs_ids.delete();
        repeat (12) rnd_step(1, 1, 1);
        chk("cont_count", obs_ids.size(), 4);
        for (int i = 0; i < 4 && i < obs_ids.size(); i++)
            chk("cont_id", obs_ids[i], i % 2);

        // Backpressure: five stalled cycles with both requesters pushing
        step(1, 3'd5, 8'hA5, 8'h0F, 0, 3'd0, 8'h00, 8'h00, 1);
        idle(1);
        held = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            rnd_step(1, 1, 0);
            if (i == 0) held = rsp_data;
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_data", rsp_data, held);
            chk("bp_busy", busy, 1'b1);
            chk("bp_ready0", req0_ready, 1'b0);
            chk("bp_ready1", req1_ready, 1'b0);
        end
        chk("bp_data_val", held, 8'hAA);
        rnd_step(1, 1, 1);
        rnd_step(1, 1, 1);
        chk("bp_next_grant", req1_ready, 1'b1);
        repeat (3) idle(1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            rnd_step(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 7));
        repeat (4) idle(1);

        // Reset while in EXEC: priority previously moved to req1
        run_op(0, 3'd0, 8'hFF, 8'h0F, 8'h0F, 0);
        step(0, 3'd0, 8'h00, 8'h00, 1, 3'd2, 8'h12, 8'h34, 1);
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", rsp_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        m_busy = 0; m_vis = 0; m_prio = 0; m_c0 = 0; m_c1 = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) idle(1);
        rnd_step(1, 1, 1);
        chk("mid_rst_prio", req0_ready, 1'b1);
        repeat (4) idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
